// File: rtl/multicycle_ctrl_pkg.sv
// Shared types, encodings and decode helpers for the multicycle ARM-subset controller.
// Imported by the condition unit and the FSM top.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  localparam int INSTR_W = 32;
  localparam int FLAGS_W = 4;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Flags are ordered {N,Z,C,V}; the NV encoding is treated as never-execute.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, r;
    {n, z, c, v} = flags;
    case (cond_t'(cond))
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic alu_op_t alu_decode(input logic [3:0] cmd);
    alu_op_t r;
    case (cmd)
      CMD_ADD: r = ALU_ADD;
      CMD_SUB: r = ALU_SUB;
      CMD_CMP: r = ALU_SUB;
      CMD_AND: r = ALU_AND;
      CMD_ORR: r = ALU_ORR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: master is the controller, slave the datapath side.
interface multicycle_ctrl_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        MemReq;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [1:0]  ResultSrc;
  logic        InstrDone;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, InstrDone
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, InstrDone
  );
endinterface

// File: rtl/multicycle_ctrl_cond_unit.sv
// NZCV flags register plus condition-field evaluation; flag updates only land
// when the instruction's condition passes.
module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_w_i,
  output logic       cond_ex_o,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;

  assign cond_ex_o = cond_check(cond_i, flags_q);
  assign flags_o   = flags_q;

  // Next flags: capture ALU flags only for a passing, flag-setting instruction.
  always_comb begin
    flags_d = flags_q;
    if (flag_w_i && cond_ex_o) begin
      flags_d = alu_flags_i;
    end else begin
      flags_d = flags_q;
    end
  end

  // Flags register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM controller: sequences fetch/decode/execute over a shared memory
// with a ready handshake and drives every datapath select and write strobe.
module multicycle_ctrl
  import arm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [3:0] rd_s;
  logic       is_cmp_s;
  logic       cond_ex_s;
  logic [3:0] flags_s;
  logic       flag_w_s;
  logic       unused_instr_s;

  logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s, reg_write_s;
  logic       alu_src_a_s, instr_done_s;
  logic [1:0] alu_src_b_s, result_src_s, reg_src_s, imm_src_s;
  alu_op_t    alu_ctrl_s;

  assign cond_s         = bus.Instr[31:28];
  assign op_s           = bus.Instr[27:26];
  assign funct_s        = bus.Instr[25:20];
  assign rd_s           = bus.Instr[15:12];
  assign is_cmp_s       = (funct_s[4:1] == CMD_CMP);
  assign unused_instr_s = ^{bus.Instr[19:16], bus.Instr[11:0], flags_s};

  cond_unit u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond_i     (cond_s),
    .alu_flags_i(bus.ALUFlags),
    .flag_w_i   (flag_w_s),
    .cond_ex_o  (cond_ex_s),
    .flags_o    (flags_s)
  );

  // Register-port and immediate selects follow the opcode in every state.
  always_comb begin
    reg_src_s = 2'b00;
    imm_src_s = 2'b00;
    case (op_s)
      OP_DP:  imm_src_s = 2'b00;
      OP_MEM: begin
        imm_src_s = 2'b01;
        reg_src_s = funct_s[0] ? 2'b00 : 2'b10;
      end
      OP_BR: begin
        imm_src_s = 2'b10;
        reg_src_s = 2'b01;
      end
      default: imm_src_s = 2'b00;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d      = state_q;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = SRCB_REG;
    alu_ctrl_s   = ALU_ADD;
    result_src_s = RES_ALUOUT;
    instr_done_s = 1'b0;
    flag_w_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (bus.MemReady) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          alu_src_a_s  = 1'b1;
          alu_src_b_s  = SRCB_FOUR;
          result_src_s = RES_ALU;
          state_d      = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // PC+8 on the ALU so R15 reads in later states see the pipeline value.
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_FOUR;
        if (!cond_ex_s || (op_s == 2'b11)) begin
          instr_done_s = 1'b1;
          state_d      = S_FETCH;
        end else begin
          case (op_s)
            OP_DP:   state_d = funct_s[5] ? S_EXECI : S_EXECR;
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_b_s = SRCB_IMM;
        state_d     = funct_s[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        state_d   = bus.MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_src_s = RES_RDATA;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
        if (bus.MemReady) begin
          instr_done_s = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_b_s = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
        alu_ctrl_s  = alu_decode(funct_s[4:1]);
        flag_w_s    = funct_s[0] | is_cmp_s;
        if (is_cmp_s) begin
          instr_done_s = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        result_src_s = RES_ALUOUT;
        reg_write_s  = 1'b1;
        pc_write_s   = (rd_s == 4'd15);
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b_s  = SRCB_IMM;
        result_src_s = RES_ALU;
        pc_write_s   = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are held low for the whole reset window, not just after the state resets.
  assign bus.MemReq     = mem_req_s    & reset;
  assign bus.MemWrite   = mem_write_s  & reset;
  assign bus.IRWrite    = ir_write_s   & reset;
  assign bus.PCWrite    = pc_write_s   & reset;
  assign bus.RegWrite   = reg_write_s  & reset;
  assign bus.InstrDone  = instr_done_s & reset;
  assign bus.AdrSrc     = adr_src_s;
  assign bus.RegSrc     = reg_src_s;
  assign bus.ImmSrc     = imm_src_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ALUControl = alu_ctrl_s;
  assign bus.ResultSrc  = result_src_s;

endmodule
